// File: rtl/cmd_phy_serdes_if.sv
// ---------------------------------------------------------------------------
// cmd_phy_serdes_if
// Host-side handshake bundle between the command master and cmd_phy_serdes.
//   REQ_in       master -> phy : command request (rising edge accepted)
//   cmd_in[37:0] master -> phy : [37:32] index, [31:0] argument
//   ACK_out      phy -> master : one-cycle command-accepted pulse
//   REQ_out      phy -> master : response valid (four-phase with ACK_in)
//   ACK_in       master -> phy : response acknowledge
//   cmd_response phy -> master : [37:32] index, [31:0] argument
//   cmd_error    phy -> master : one-cycle error pulse
// ---------------------------------------------------------------------------
interface cmd_phy_serdes_if;
  logic        REQ_in;
  logic [37:0] cmd_in;
  logic        ACK_out;
  logic        REQ_out;
  logic        ACK_in;
  logic [37:0] cmd_response;
  logic        cmd_error;

  modport master (
    output REQ_in, cmd_in, ACK_in,
    input  ACK_out, REQ_out, cmd_response, cmd_error
  );

  modport slave (
    input  REQ_in, cmd_in, ACK_in,
    output ACK_out, REQ_out, cmd_response, cmd_error
  );
endinterface

// File: rtl/cmd_phy_serdes.sv
// ---------------------------------------------------------------------------
// cmd_phy_serdes
// SD command-line serializer/deserializer. Takes a 38-bit {index, argument}
// command from the master, wraps it into the 48-bit SD frame
// {start 0, transmission 1, cmd, CRC7, end 1}, shifts it out MSB first one bit
// per sd_tick, releases the line, captures the 48-bit response and hands its
// {index, argument} field back over a four-phase REQ/ACK handshake.
//
// Ports:
//   CLK_host      host clock
//   reset         synchronous, active-high
//   sd_tick       one-cycle enable per SD bit period
//   host          cmd_phy_serdes_if.slave (REQ_in/cmd_in/ACK_out/REQ_out/
//                 ACK_in/cmd_response/cmd_error)
//   cmd_line_out  CMD line drive value
//   cmd_line_oe   CMD line output enable
//   cmd_line_in   sampled CMD line
//   busy          high whenever the FSM is not idle
//
// Build option: define CMD_RESP_CRC_CHECK_EN to treat a response CRC7 mismatch
// as an error. Without it the response CRC field is shifted in but ignored
// (R3 responses carry no valid CRC); start/transmission/end checks always run.
// ---------------------------------------------------------------------------
module cmd_phy_serdes #(
  parameter int TURN_TICKS    = 2,
  parameter int RESP_WAIT_MAX = 64
) (
  input  logic             CLK_host,
  input  logic             reset,
  input  logic             sd_tick,
  cmd_phy_serdes_if.slave  host,
  output logic             cmd_line_out,
  output logic             cmd_line_oe,
  input  logic             cmd_line_in,
  output logic             busy
);

  localparam int CNT_MAX = (TURN_TICKS > RESP_WAIT_MAX) ? TURN_TICKS : RESP_WAIT_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESP_WAIT_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TURN,
    WAIT_START,
    RECV,
    CHECK,
    HANDOFF
  } state_t;

  state_t           state;
  logic             req_q;
  logic             accept;
  logic [47:0]      tx_sr;
  // Response bits 46..0; bit 47 is the start bit and is known to be 0.
  logic [46:0]      rx_sr;
  logic [5:0]       bit_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic             resp_bad;

  // CRC7, polynomial x^7 + x^3 + 1, initial 0, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign accept = (state == IDLE) && host.REQ_in && !req_q;
  assign busy   = (state != IDLE);

  always_comb begin
    resp_bad = rx_sr[46] || !rx_sr[0];
`ifdef CMD_RESP_CRC_CHECK_EN
    resp_bad = resp_bad || (crc7({1'b0, rx_sr[46:8]}) != rx_sr[7:1]);
`endif
  end

  // Frame / response shift registers (data path, no reset).
  always_ff @(posedge CLK_host) begin
    if (accept) begin
      tx_sr <= {2'b01, host.cmd_in, crc7({2'b01, host.cmd_in}), 1'b1};
    end else if (state == SEND && sd_tick && bit_cnt != 6'd48) begin
      tx_sr <= {tx_sr[46:0], 1'b0};
    end
    if (state == RECV && sd_tick) begin
      rx_sr <= {rx_sr[45:0], cmd_line_in};
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge CLK_host) begin
    if (reset) begin
      state             <= IDLE;
      req_q             <= 1'b0;
      host.ACK_out      <= 1'b0;
      host.REQ_out      <= 1'b0;
      host.cmd_error    <= 1'b0;
      host.cmd_response <= '0;
      cmd_line_out      <= 1'b1;
      cmd_line_oe       <= 1'b0;
      bit_cnt           <= '0;
      tick_cnt          <= '0;
    end else begin
      req_q          <= host.REQ_in;
      host.ACK_out   <= 1'b0;
      host.cmd_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            host.ACK_out <= 1'b1;
            cmd_line_oe  <= 1'b1;
            cmd_line_out <= 1'b1;
            bit_cnt      <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (sd_tick) begin
            // The tick after bit 0 releases the line.
            if (bit_cnt == 6'd48) begin
              cmd_line_oe  <= 1'b0;
              cmd_line_out <= 1'b1;
              bit_cnt      <= '0;
              tick_cnt     <= '0;
              state        <= TURN;
            end else begin
              cmd_line_out <= tx_sr[47];
              bit_cnt      <= bit_cnt + 6'd1;
            end
          end
        end
        TURN: begin
          if (sd_tick) begin
            if (tick_cnt == TURN_LAST) begin
              tick_cnt <= '0;
              state    <= WAIT_START;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        WAIT_START: begin
          if (sd_tick) begin
            if (!cmd_line_in) begin
              // Start bit counts as received bit 47.
              bit_cnt  <= 6'd1;
              tick_cnt <= '0;
              state    <= RECV;
            end else if (tick_cnt == WAIT_LAST) begin
              host.cmd_error <= 1'b1;
              tick_cnt       <= '0;
              state          <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        RECV: begin
          if (sd_tick) begin
            if (bit_cnt == 6'd47) begin
              bit_cnt <= '0;
              state   <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        CHECK: begin
          host.cmd_response <= rx_sr[45:8];
          if (resp_bad) begin
            host.cmd_error <= 1'b1;
            state          <= IDLE;
          end else begin
            host.REQ_out <= 1'b1;
            state        <= HANDOFF;
          end
        end
        HANDOFF: begin
          // REQ_out doubles as the handshake phase flag.
          if (host.REQ_out) begin
            if (host.ACK_in) host.REQ_out <= 1'b0;
          end else if (!host.ACK_in) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_phy_serdes.sv
`timescale 1ns/1ps
module tb_cmd_phy_serdes;
  localparam int TURN_TICKS    = 2;
  localparam int RESP_WAIT_MAX = 64;

  logic CLK_host    = 1'b0;
  logic reset       = 1'b1;
  logic sd_tick     = 1'b0;
  logic cmd_line_in = 1'b1;
  logic cmd_line_out, cmd_line_oe, busy;

  cmd_phy_serdes_if host();

  cmd_phy_serdes #(.TURN_TICKS(TURN_TICKS), .RESP_WAIT_MAX(RESP_WAIT_MAX)) dut (
    .CLK_host    (CLK_host),
    .reset       (reset),
    .sd_tick     (sd_tick),
    .host        (host),
    .cmd_line_out(cmd_line_out),
    .cmd_line_oe (cmd_line_oe),
    .cmd_line_in (cmd_line_in),
    .busy        (busy)
  );

  always #5 CLK_host = ~CLK_host;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^7 divided by G(x)=x^7+x^3+1 (0x89).
  function automatic logic [6:0] ref_crc(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    return v[6:0];
  endfunction

  typedef struct {
    logic        err;
    logic        chk_resp;
    logic [37:0] resp;
    int          ticks;
  } outcome_t;

  logic [47:0] exp_frame_q[$];
  outcome_t    exp_out_q[$];

  // Card emulator configuration
  int          tick_div      = 4;
  bit          card_armed    = 0;
  bit          card_has_resp = 0;
  logic [47:0] card_resp     = '0;
  int          card_delay    = 0;

  // Shared monitor state
  int          ack_count = 0;
  int          cap_n     = 0;
  logic [47:0] cap       = '0;

  // sd_tick generator and card: after the line is released, idle 'card_delay'
  // ticks, then drive the 48 response bits one per tick.
  int   drv_cyc = 0;
  int   drv_tcount = 0;
  logic drv_prev_oe = 1'b0;
  bit   drv_active = 0;
  initial begin
    forever begin
      @(negedge CLK_host);
      if (reset) begin
        drv_active  = 0;
        cmd_line_in = 1'b1;
      end
      if (drv_prev_oe && !cmd_line_oe && card_armed) begin
        drv_active = 1;
        drv_tcount = 0;
        card_armed = 0;
      end
      drv_prev_oe = cmd_line_oe;
      drv_cyc++;
      if (drv_cyc >= tick_div) begin
        drv_cyc = 0;
        sd_tick = 1'b1;
        if (drv_active) begin
          drv_tcount++;
          if (card_has_resp && drv_tcount > card_delay && drv_tcount <= card_delay + 48)
            cmd_line_in = card_resp[47 - (drv_tcount - card_delay - 1)];
          else
            cmd_line_in = 1'b1;
          if (drv_tcount > card_delay + 48) drv_active = 0;
        end
      end else begin
        sd_tick = 1'b0;
      end
    end
  end

  // Master response-side handshake
  initial begin
    host.ACK_in = 1'b0;
    forever begin
      @(posedge CLK_host); #1;
      if (host.REQ_out && !reset) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK_host);
        @(negedge CLK_host);
        host.ACK_in = 1'b1;
        @(posedge CLK_host); #1;
        check("req_out_clear_on_ack", host.REQ_out, 1'b0);
        @(negedge CLK_host);
        @(negedge CLK_host);
        host.ACK_in = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  logic     mon_prev_oe = 1'b0;
  logic     prev_ack = 1'b0, prev_err = 1'b0, prev_req = 1'b0;
  int       tick_since = -1;
  outcome_t mo;
  initial begin
    forever begin
      @(posedge CLK_host); #1;
      if (reset) begin
        cap_n       = 0;
        mon_prev_oe = 1'b0;
        tick_since  = -1;
        prev_ack    = 1'b0;
        prev_err    = 1'b0;
        prev_req    = 1'b0;
        continue;
      end
      if (host.ACK_out) begin
        ack_count++;
        check("ack_pulse_width", prev_ack, 1'b0);
      end
      if (sd_tick && mon_prev_oe && cmd_line_oe && cap_n < 48) begin
        cap = {cap[46:0], cmd_line_out};
        cap_n++;
      end
      if (tick_since >= 0 && sd_tick) tick_since++;
      if (mon_prev_oe && !cmd_line_oe) begin
        if (exp_frame_q.size() == 0) begin
          check("frame_unexpected", 1'b1, 1'b0);
        end else begin
          check("frame_bits", cap_n, 48);
          check("frame", cap, exp_frame_q.pop_front());
        end
        cap_n      = 0;
        tick_since = 0;
      end
      mon_prev_oe = cmd_line_oe;
      if (host.cmd_error) check("err_pulse_width", prev_err, 1'b0);
      if ((host.REQ_out && !prev_req) || host.cmd_error) begin
        if (exp_out_q.size() == 0) begin
          check("outcome_unexpected", 1'b1, 1'b0);
        end else begin
          mo = exp_out_q.pop_front();
          check("outcome_err", host.cmd_error, mo.err);
          check("outcome_req", host.REQ_out, !mo.err);
          check("outcome_ticks", tick_since, mo.ticks);
          if (mo.chk_resp) check("cmd_response", host.cmd_response, mo.resp);
        end
        tick_since = -1;
      end
      prev_ack = host.ACK_out;
      prev_err = host.cmd_error;
      prev_req = host.REQ_out;
    end
  end

  task automatic run_cmd(input logic [37:0] cmd, input logic [47:0] frame_lit,
                         input bit has_resp, input logic [47:0] resp,
                         input int delay, input bit hold_req);
    int          base_ack;
    int          n;
    logic [39:0] d;
    outcome_t    o;
    bit          bad;
    base_ack = ack_count;
    d = {2'b01, cmd};
    exp_frame_q.push_back(frame_lit != 48'h0 ? frame_lit : {d, ref_crc(d), 1'b1});
    if (!has_resp) begin
      o = '{1'b1, 1'b0, 38'h0, TURN_TICKS + RESP_WAIT_MAX};
    end else begin
      bad = resp[46] || !resp[0];
`ifdef CMD_RESP_CRC_CHECK_EN
      bad = bad || (ref_crc(resp[47:8]) != resp[7:1]);
`endif
      o = '{bad, 1'b1, resp[45:8], delay + 48};
    end
    exp_out_q.push_back(o);
    card_resp     = resp;
    card_has_resp = has_resp;
    card_delay    = has_resp ? delay : 1000;
    card_armed    = 1;
    @(negedge CLK_host);
    host.cmd_in = cmd;
    host.REQ_in = 1'b1;
    if (!hold_req) begin
      repeat ($urandom_range(1, 3)) @(negedge CLK_host);
      host.REQ_in = 1'b0;
    end
    n = 0;
    while (!busy && n < 100) begin @(negedge CLK_host); n++; end
    while (busy && n < 20000) begin @(negedge CLK_host); n++; end
    check("txn_done_busy", busy, 1'b0);
    check("ack_once", ack_count - base_ack, 1);
    if (hold_req) begin
      repeat (100) @(negedge CLK_host);
      check("held_req_no_restart_busy", busy, 1'b0);
      check("held_req_no_new_ack", ack_count - base_ack, 1);
      check("held_req_no_frame", cap_n, 0);
      host.REQ_in = 1'b0;
    end
    repeat (3) @(negedge CLK_host);
  endtask

  logic [37:0] r_cmd, r_body;
  logic [39:0] r_d;
  logic [6:0]  r_crc;
  logic [47:0] r_resp;
  bit          r_has;
  int          base_ack2;
  int          nw;

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    host.REQ_in = 1'b0;
    host.cmd_in = '0;
    reset = 1'b1;
    repeat (3) @(negedge CLK_host);
    check("rst_oe", cmd_line_oe, 1'b0);
    check("rst_line_out", cmd_line_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req_out", host.REQ_out, 1'b0);
    check("rst_ack_out", host.ACK_out, 1'b0);
    check("rst_cmd_error", host.cmd_error, 1'b0);
    check("rst_cmd_response", host.cmd_response, 38'h0);
    reset = 1'b0;
    repeat (4) @(negedge CLK_host);

    // CMD0, no response, REQ_in held high throughout
    run_cmd({6'd0, 32'h0}, 48'h40_0000_0000_95, 1'b0, 48'h0, 0, 1'b1);
    // CMD8 with good response
    run_cmd({6'd8, 32'h1AA}, 48'h48_0000_01AA_87, 1'b1, 48'h08_0000_01AA_13, 5, 1'b0);
    // bad end bit
    run_cmd({6'd8, 32'h1AA}, 48'h48_0000_01AA_87, 1'b1, 48'h08_0000_01AA_12, 5, 1'b0);
    // bad CRC
    run_cmd({6'd8, 32'h1AA}, 48'h48_0000_01AA_87, 1'b1, 48'h08_0000_01AA_15, 5, 1'b0);
    // bad transmission bit
    run_cmd({6'd8, 32'h1AA}, 48'h48_0000_01AA_87, 1'b1, 48'h48_0000_01AA_13, 7, 1'b0);
    // earliest and latest start-bit positions
    run_cmd({6'd8, 32'h1AA}, 48'h0, 1'b1, 48'h08_0000_01AA_13, TURN_TICKS, 1'b0);
    run_cmd({6'd8, 32'h1AA}, 48'h0, 1'b1, 48'h08_0000_01AA_13, TURN_TICKS + RESP_WAIT_MAX - 1, 1'b0);

    // Reset in the middle of SEND (bit 20 on the line)
    card_armed = 0;
    base_ack2 = ack_count;
    @(negedge CLK_host);
    host.cmd_in = {6'd17, 32'hDEAD_BEEF};
    host.REQ_in = 1'b1;
    @(negedge CLK_host);
    host.REQ_in = 1'b0;
    nw = 0;
    while (cap_n < 28 && nw < 5000) begin @(negedge CLK_host); nw++; end
    check("rst_mid_reached_bit20", cap_n, 28);
    check("rst_mid_ack", ack_count - base_ack2, 1);
    reset = 1'b1;
    @(posedge CLK_host); #1;
    check("rst_mid_oe", cmd_line_oe, 1'b0);
    check("rst_mid_line_out", cmd_line_out, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_req_out", host.REQ_out, 1'b0);
    check("rst_mid_cmd_response", host.cmd_response, 38'h0);
    @(negedge CLK_host);
    reset = 1'b0;
    repeat (3) @(negedge CLK_host);
    run_cmd({6'd17, 32'hDEAD_BEEF}, 48'h0, 1'b1, 48'h11_DEAD_BEEF_01, 4, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      tick_div = $urandom_range(2, 5);
      r_cmd  = {6'($urandom_range(0, 63)), 32'($urandom())};
      r_body = {6'($urandom_range(0, 63)), 32'($urandom())};
      r_d    = {1'b0, ($urandom_range(0, 7) == 0), r_body};
      r_crc  = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : ref_crc(r_d);
      r_resp = {r_d, r_crc, ($urandom_range(0, 7) != 0)};
      r_has  = ($urandom_range(0, 9) != 0);
      run_cmd(r_cmd, 48'h0, r_has, r_resp, $urandom_range(TURN_TICKS, 30), 1'b0);
    end

    check("exp_queues_empty", exp_frame_q.size() + exp_out_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
